// File: rtl/seq_restoring_div_16_8.sv
// Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per cycle.
// Define DIV_APPROX_EN to skip the APPROX_BITS least-significant iterations (bounded-error approximate mode).
module seq_restoring_div_16_8 #(
  parameter int N           = 8,
  parameter int APPROX_BITS = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
);

`ifdef DIV_APPROX_EN
  localparam int SKIP = APPROX_BITS;
`else
  localparam int SKIP = 0;
`endif
  localparam int ITER = 2*N - SKIP;
  localparam int CW   = $clog2(2*N);

  if (APPROX_BITS < 1 || APPROX_BITS > 2*N-1) begin : g_bad_approx_bits
    $error("APPROX_BITS must lie in 1..2N-1");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] dvd_q, dvd_d;
  logic [2*N-1:0] quo_q, quo_d;
  logic [N-1:0]   dsr_q, dsr_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     trial;
  logic           qBit;
  logic [2*N-1:0] quoShift;

  // The partial remainder stays below the divisor, so N bits hold it; only the trial needs N+1.
  always_comb begin
    trial    = {rem_q, dvd_q[2*N-1]};
    qBit     = (trial >= {1'b0, dsr_q});
    quoShift = {quo_q[2*N-2:0], qBit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          dvd_d   = dividend;
          dsr_d   = divisor;
          state_d = RUN;
          if (divisor == '0) begin
            // A zero divisor spends a single RUN cycle with the result already loaded.
            quo_d = '1;
            rem_d = dividend[N-1:0];
            dbz_d = 1'b1;
            cnt_d = '0;
          end else begin
            quo_d = '0;
            rem_d = '0;
            dbz_d = 1'b0;
            cnt_d = CW'(ITER - 1);
          end
        end
      end
      RUN: begin
        if (!dbz_q) begin
          rem_d = qBit ? (trial[N-1:0] - dsr_q) : trial[N-1:0];
          dvd_d = dvd_q << 1;
          quo_d = (cnt_q == '0) ? (quoShift << SKIP) : quoShift;
        end
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
